// File: rtl/ieee_fp_divider_if.sv
// Handshake and operand/result bundle for the single-precision divider.
interface ieee_fp_divider_if;
    logic        start;
    logic [31:0] number1;
    logic [31:0] number2;
    logic [31:0] result;
    logic        busy;
    logic        done;

    modport master (output start, number1, number2, input result, busy, done);
    modport slave  (input start, number1, number2, output result, busy, done);
endinterface

// File: rtl/ieee_fp_divider.sv
// Fixed-latency IEEE-754 single-precision divider (restoring, one quotient bit per cycle).
// FP_DIV_ROUND_NEAREST_EN selects round-to-nearest-even; default build truncates.
module ieee_fp_divider (
    input  logic            clk,
    input  logic            rstn,
    ieee_fp_divider_if.slave bus
);

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORMALIZE, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [25:0]        rem_q, rem_d;
    logic [23:0]        div_q, div_d;
    logic [25:0]        quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               spec_q, spec_d;
    logic [31:0]        spec_val_q, spec_val_d;
    logic [31:0]        result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef FP_DIV_ROUND_NEAREST_EN
    logic               sticky_q, sticky_d;
`endif

    logic [7:0]         e1, e2;
    logic [22:0]        f1, f2;
    logic               z1, z2, i1, i2, n1, n2, s_x;
    logic               rem_ge, rnd_inc;
    logic [24:0]        mant_rnd;
    logic signed [9:0]  exp_rnd;
    logic [22:0]        frac_fin;
    logic [31:0]        packed_res;

    // Denormals have a zero exponent field and are deliberately classed as zero.
    assign e1  = a_q[30:23];
    assign e2  = b_q[30:23];
    assign f1  = a_q[22:0];
    assign f2  = b_q[22:0];
    assign z1  = (e1 == 8'd0);
    assign z2  = (e2 == 8'd0);
    assign i1  = (e1 == 8'hFF) && (f1 == 23'd0);
    assign i2  = (e2 == 8'hFF) && (f2 == 23'd0);
    assign n1  = (e1 == 8'hFF) && (f1 != 23'd0);
    assign n2  = (e2 == 8'hFF) && (f2 != 23'd0);
    assign s_x = a_q[31] ^ b_q[31];

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef FP_DIV_ROUND_NEAREST_EN
        sticky_d   = sticky_q;
        rnd_inc    = quo_q[1] & (quo_q[0] | sticky_q | quo_q[2]);
`else
        rnd_inc    = 1'b0;
`endif
        rem_ge   = (rem_q >= {2'b00, div_q});
        mant_rnd = {1'b0, quo_q[25:2]} + {24'd0, rnd_inc};
        if (mant_rnd[24]) begin
            exp_rnd  = exp_q + 10'sd1;
            frac_fin = mant_rnd[23:1];
        end else begin
            exp_rnd  = exp_q;
            frac_fin = mant_rnd[22:0];
        end
        if (exp_rnd <= 10'sd0)
            packed_res = {sign_q, 31'd0};
        else if (exp_rnd >= 10'sd255)
            packed_res = {sign_q, 8'hFF, 23'd0};
        else
            packed_res = {sign_q, exp_rnd[7:0], frac_fin};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.number1;
                    b_d     = bus.number2;
                    busy_d  = 1'b1;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d  = s_x;
                exp_d   = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
                rem_d   = {2'b00, (z1 ? 24'd0 : {1'b1, f1})};
                div_d   = z2 ? 24'd0 : {1'b1, f2};
                quo_d   = 26'd0;
                cnt_d   = 5'd25;
                spec_d  = 1'b1;
                if (n1 | n2 | (z1 & z2) | (i1 & i2))
                    spec_val_d = 32'h7FC0_0000;
                else if (i1 | z2)
                    spec_val_d = {s_x, 8'hFF, 23'd0};
                else if (i2 | z1)
                    spec_val_d = {s_x, 31'd0};
                else begin
                    spec_d     = 1'b0;
                    spec_val_d = 32'd0;
                end
                state_d = DIVIDE;
            end
            DIVIDE: begin
                quo_d = {quo_q[24:0], rem_ge};
                rem_d = (rem_ge ? (rem_q - {2'b00, div_q}) : rem_q) << 1;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0)
                    state_d = NORMALIZE;
            end
            NORMALIZE: begin
                if (!quo_q[25]) begin
                    quo_d = {quo_q[24:0], 1'b0};
                    exp_d = exp_q - 10'sd1;
                end
`ifdef FP_DIV_ROUND_NEAREST_EN
                sticky_d = |rem_q;
`endif
                state_d = ROUND;
            end
            ROUND: begin
                // Result and done are registered on entry to DONE so both are visible during it.
                result_d = spec_q ? spec_val_q : packed_res;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q    <= IDLE;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            sign_q     <= 1'b0;
            exp_q      <= 10'sd0;
            rem_q      <= 26'd0;
            div_q      <= 24'd0;
            quo_q      <= 26'd0;
            cnt_q      <= 5'd0;
            spec_q     <= 1'b0;
            spec_val_q <= 32'd0;
            result_q   <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef FP_DIV_ROUND_NEAREST_EN
            sticky_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef FP_DIV_ROUND_NEAREST_EN
            sticky_q   <= sticky_d;
`endif
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_ieee_fp_divider.sv
// Bench for ieee_fp_divider: directed table, random vectors against an integer model, protocol/reset sequences.
// Cycle 1 is the first cycle after the start-sampling edge; done is expected in cycle 30.
module tb_ieee_fp_divider;

    logic clk;
    logic rstn;
    int   passed;
    int   total;

    ieee_fp_divider_if bus ();

    ieee_fp_divider dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Exact integer long division of the significands, then IEEE rounding by rule.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint unsigned num, den, q, r, mant, rest, half;
        int          e, sh;
        sign   = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 0);
        b_nan  = (eb == 8'hFF) && (fb != 0);
        a_inf  = (ea == 8'hFF) && (fa == 0);
        b_inf  = (eb == 8'hFF) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC00000;
        if (a_inf || b_zero) return {sign, 8'hFF, 23'd0};
        if (b_inf || a_zero) return {sign, 31'd0};
        num = (64'(1) << 23 | 64'(fa)) << 40;
        den = (64'(1) << 23) | 64'(fb);
        q = num / den;
        r = num % den;
        e = int'(ea) - int'(eb) + 127;
        if (q >= (64'(1) << 40)) sh = 17;
        else begin
            sh = 16;
            e  = e - 1;
        end
        mant = q >> sh;
        rest = q & ((64'(1) << sh) - 1);
        half = 64'(1) << (sh - 1);
`ifdef FP_DIV_ROUND_NEAREST_EN
        if (rest > half || (rest == half && (r != 0 || mant[0]))) mant = mant + 1;
`endif
        if (mant == (64'(1) << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e <= 0)   return {sign, 31'd0};
        if (e >= 255) return {sign, 8'hFF, 23'd0};
        return {sign, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned kind;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        kind = $urandom_range(0, 19);
        s    = 1'($urandom_range(0, 1));
        f    = 23'($urandom);
        case (kind)
            0:       return {s, 31'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, (f | 23'd1)};
            3:       return {s, 8'd0, (f | 23'd1)};
            4, 5, 6: e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {s, e, f};
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat,
                           output bit overlap, output bit busy1);
        int n;
        @(negedge clk);
        bus.number1 = a;
        bus.number2 = b;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy1     = bus.busy;
        overlap   = 1'b0;
        lat       = -1;
        res       = 32'hxxxxxxxx;
        n         = 1;
        while (n <= 100) begin
            if (bus.busy && bus.done) overlap = 1'b1;
            if (bus.done) begin
                lat = n;
                res = bus.result;
                break;
            end
            bus.number1 = $urandom;
            bus.number2 = $urandom;
            @(negedge clk);
            n++;
        end
    endtask

    vec_t        vecs[$];
    logic [31:0] res, first_res, a, b;
    int          lat, dones, done_n, overlaps;
    bit          ov, busy1;

    initial begin
        passed = 0;
        total  = 0;
        overlaps = 0;
        rstn        = 1'b1;
        bus.start   = 1'b0;
        bus.number1 = 32'd0;
        bus.number2 = 32'd0;

`ifdef FP_DIV_ROUND_NEAREST_EN
        vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "1div3"});
        vecs.push_back('{32'h40000000, 32'h40400000, 32'h3F2AAAAB, "2div3"});
`else
        vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, "1div3"});
        vecs.push_back('{32'h40000000, 32'h40400000, 32'h3F2AAAAA, "2div3"});
`endif
        vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, "6div2"});
        vecs.push_back('{32'hC0F00000, 32'h40200000, 32'hC0400000, "neg7p5div2p5"});
        vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, "1div0"});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, "0div0"});
        vecs.push_back('{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, "overflow"});
        vecs.push_back('{32'h00800000, 32'h40000000, 32'h00000000, "underflow"});
        vecs.push_back('{32'h7F800000, 32'h3F800000, 32'h7F800000, "infdiv1"});
        vecs.push_back('{32'h3F800000, 32'hFF800000, 32'h80000000, "1divneginf"});
        vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, "negzerodiv2"});
        vecs.push_back('{32'h7F800001, 32'h3F800000, 32'h7FC00000, "nandiv1"});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, "infdivinf"});
        vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, "denormdiv1"});
        vecs.push_back('{32'h3F800000, 32'h00000001, 32'h7F800000, "1divdenorm"});
        vecs.push_back('{32'hBF800000, 32'h3F800000, 32'hBF800000, "neg1div1"});
        vecs.push_back('{32'h40400000, 32'h40400000, 32'h3F800000, "3div3"});

        repeat (2) @(negedge clk);
        chk("reset_result", bus.result, 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, res, lat, ov, busy1);
            if (ov) overlaps++;
            chk({vecs[i].name, "_result"}, res, vecs[i].exp);
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'd30);
            chk({vecs[i].name, "_busy_c1"}, 32'(busy1), 32'd1);
            @(negedge clk);
            chk({vecs[i].name, "_done_pulse"}, 32'(bus.done), 32'd0);
            chk({vecs[i].name, "_result_hold"}, bus.result, vecs[i].exp);
        end

        for (int k = 0; k < 150; k++) begin
            a = rand_fp();
            b = rand_fp();
            run_div(a, b, res, lat, ov, busy1);
            if (ov) overlaps++;
            chk($sformatf("rand%0d_%h_%h", k, a, b), res, ref_div(a, b));
            chk($sformatf("rand%0d_latency", k), 32'(lat), 32'd30);
        end

        // Second start at cycle 10 must be ignored; operand lines change too.
        @(negedge clk);
        bus.number1 = 32'h40C00000;
        bus.number2 = 32'h40000000;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        done_n = -1;
        first_res = 32'h0;
        for (int n = 1; n <= 45; n++) begin
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    first_res = bus.result;
                    done_n    = n;
                end
            end
            if (n == 10) begin
                bus.start   = 1'b1;
                bus.number1 = 32'h3F800000;
                bus.number2 = 32'h40400000;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("restart_done_count", 32'(dones), 32'd1);
        chk("restart_result", first_res, 32'h40400000);
        chk("restart_latency", 32'(done_n), 32'd30);

        // Reset at cycle 15 aborts with no done pulse.
        bus.number1 = 32'h40C00000;
        bus.number2 = 32'h40000000;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 1; n < 15; n++) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("midreset_result", bus.result, 32'h0);
        chk("midreset_busy", 32'(bus.busy), 32'h0);
        chk("midreset_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        rstn = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        chk("midreset_no_done", 32'(dones), 32'd0);
        chk("midreset_idle_busy", 32'(bus.busy), 32'd0);
        run_div(32'h40C00000, 32'h40000000, res, lat, ov, busy1);
        if (ov) overlaps++;
        chk("post_reset_result", res, 32'h40400000);
        chk("post_reset_latency", 32'(lat), 32'd30);

        chk("busy_done_exclusive", 32'(overlaps), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ieee_fp_divider.md
IEEE_FP_DIVIDER -- requirements
Module: ieee_fp_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-002 SHALL have port rstn, input, 1 bit: asynchronous, active-high reset (asserted = 1).
REQ-003 SHALL have port start, input, 1 bit: request to divide; sampled only in IDLE.
REQ-004 SHALL have port number1, input, 32 bits: IEEE-754 single-precision dividend.
REQ-005 SHALL have port number2, input, 32 bits: IEEE-754 single-precision divisor.
REQ-006 SHALL have port result, output, 32 bits: quotient number1/number2; holds its value until the next done.
REQ-007 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse when result is valid.

Function
REQ-009 SHALL implement FSM states IDLE, UNPACK, DIVIDE, NORMALIZE, ROUND, DONE.
REQ-010 SHALL leave IDLE for UNPACK only on start=1; SHALL register number1/number2 on that edge.
REQ-011 UNPACK SHALL split sign/exponent/mantissa, insert the hidden 1, compute sign = s1 XOR s2 and exponent = e1 - e2 + 127 (10-bit signed intermediate), and flag special cases.
REQ-012 DIVIDE SHALL run exactly 26 restoring-division iterations, one quotient bit per cycle: 24 mantissa bits + guard + round. Remainder != 0 at the end SHALL form the sticky bit.
REQ-013 NORMALIZE SHALL left-shift the quotient by 1 and decrement the exponent when the quotient MSB is 0.
REQ-014 ROUND SHALL apply the rounding mode (REQ-024). Mantissa carry-out SHALL renormalize and increment the exponent.
REQ-015 DONE SHALL update result, pulse done for one cycle, and return to IDLE.
REQ-016 Latency SHALL be fixed at 30 cycles from the start-sampling edge to the done-high cycle, including special cases. Special cases SHALL still traverse every state and override the result in DONE.
REQ-017 start while busy SHALL be ignored. Input changes while busy SHALL have no effect.
REQ-018 A new start is accepted in the cycle after done (IDLE). done and busy SHALL never be high together.
REQ-019 Special cases SHALL be resolved as follows:
  - NaN operand, 0/0, or inf/inf -> 0x7FC00000.
  - finite/0 -> signed infinity.
  - inf/finite -> signed infinity.
  - finite/inf -> signed zero.
  - 0/nonzero -> signed zero.
REQ-020 Denormal inputs SHALL be treated as zero. A final exponent <= 0 SHALL flush to signed zero.
REQ-021 A final exponent >= 255 SHALL produce signed infinity.

Reset
REQ-022 rstn=1 SHALL asynchronously force the following: state=IDLE, result=0x00000000, busy=0, done=0, and all internal registers cleared.
REQ-023 Reset mid-operation SHALL abort the division with no done pulse. After release, the block SHALL accept a new start.

Configuration
REQ-024 Macro FP_DIV_ROUND_NEAREST_EN:
  - Defined: round-to-nearest-even using guard/round/sticky.
  - Undefined: truncation (round toward zero). The ROUND state remains, so latency is unchanged.

Verification
REQ-025 6.0/2.0: number1=0x40C00000, number2=0x40000000, start pulse -> result=0x40400000, done at cycle 30.
REQ-026 1.0/3.0: 0x3F800000/0x40400000 -> 0x3EAAAAAB with FP_DIV_ROUND_NEAREST_EN; 0x3EAAAAAA without.
REQ-027 Sign and specials:
  - 0xC0F00000/0x40200000 -> 0xC0400000.
  - 0x3F800000/0x00000000 -> 0x7F800000.
  - 0x00000000/0x00000000 -> 0x7FC00000.
REQ-028 Overflow/underflow: 0x7F7FFFFF/0x3F000000 -> 0x7F800000; 0x00800000/0x40000000 -> 0x00000000.
REQ-029 Protocol: a second start at cycle 10 is ignored (single done, first result). Reset at cycle 15 -> outputs zero, no done; a following 6.0/2.0 completes correctly.
